// File: rtl/seg_display_scanner.sv
// Time-multiplexed scanner for a four-digit common-anode seven-segment display.
// It lights one digit per scanTick and adds ghost blanking, leading-zero blanking, per-digit blink and decimal points.
module seg_display_scanner #(
  parameter int GhostCycles = 8,
  parameter int NumDigits   = 4
) (
  input  logic                   MasterClock,
  input  logic                   ResetN,
  input  logic                   scanTick,
  input  logic                   blinkTick,
  input  logic [4*NumDigits-1:0] value,
  input  logic [NumDigits-1:0]   digitEnable,
  input  logic [NumDigits-1:0]   blinkMask,
  input  logic [NumDigits-1:0]   dpMask,
  input  logic                   lzBlank,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [NumDigits-1:0]   an
);

  localparam int IdxW   = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam int GhostW = (GhostCycles > 0) ? $clog2(GhostCycles + 1) : 1;
  localparam logic [IdxW-1:0]      LastIdx   = IdxW'(NumDigits - 1);
  localparam logic [GhostW-1:0]    GhostLoad = GhostW'(GhostCycles);
  localparam logic [NumDigits-1:0] Digit0    = NumDigits'(1);

  // Shadow copy of the display inputs, refreshed once per frame so a frame never tears.
  typedef struct packed {
    logic [4*NumDigits-1:0] value;
    logic [NumDigits-1:0]   digitEnable;
    logic [NumDigits-1:0]   blinkMask;
    logic [NumDigits-1:0]   dpMask;
    logic                   lzBlank;
  } frameT;

  logic [IdxW-1:0]   idx, idxNext;
  logic [GhostW-1:0] ghostCnt, ghostCntNext;
  logic              blinkPhase, blinkPhaseNext;
  frameT             frame, frameNext;
  logic              frameWrap;
  logic [3:0]        nibble;
  logic              upperZero;
  logic              lzBlanked;
  logic              lit;

  function automatic logic [6:0] hexToSeg(input logic [3:0] h);
    case (h)
      4'h0: hexToSeg = 7'h40;
      4'h1: hexToSeg = 7'h79;
      4'h2: hexToSeg = 7'h24;
      4'h3: hexToSeg = 7'h30;
      4'h4: hexToSeg = 7'h19;
      4'h5: hexToSeg = 7'h12;
      4'h6: hexToSeg = 7'h02;
      4'h7: hexToSeg = 7'h78;
      4'h8: hexToSeg = 7'h00;
      4'h9: hexToSeg = 7'h10;
      4'hA: hexToSeg = 7'h08;
      4'hB: hexToSeg = 7'h03;
      4'hC: hexToSeg = 7'h46;
      4'hD: hexToSeg = 7'h21;
      4'hE: hexToSeg = 7'h06;
      default: hexToSeg = 7'h0E;
    endcase
  endfunction

  // Outputs are registered from the next state, so a digit's seg is valid one cycle after its tick.
  // Its anode is valid at tick + 1 + GhostCycles.
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise a path that leaves it unassigned infers a latch.
    frameWrap      = scanTick && (idx == LastIdx);
    idxNext        = idx;
    ghostCntNext   = ghostCnt;
    frameNext      = frame;
    blinkPhaseNext = blinkPhase ^ blinkTick;

    if (scanTick) begin
      idxNext      = frameWrap ? '0 : idx + IdxW'(1);
      ghostCntNext = GhostLoad;
    end else if (ghostCnt != '0) begin
      ghostCntNext = ghostCnt - GhostW'(1);
    end

    if (frameWrap) begin
      frameNext = {value, digitEnable, blinkMask, dpMask, lzBlank};
    end

    nibble    = frameNext.value[4*int'(idxNext) +: 4];
    upperZero = 1'b1;
    for (int k = 0; k < NumDigits; k++) begin
      if (k >= int'(idxNext) && frameNext.value[4*k +: 4] != 4'h0) upperZero = 1'b0;
    end
    lzBlanked = frameNext.lzBlank && upperZero && (idxNext != '0);

    lit = (ghostCntNext == '0) && frameNext.digitEnable[idxNext] &&
          !(blinkPhaseNext && frameNext.blinkMask[idxNext]) && !lzBlanked;
  end

  always_ff @(posedge MasterClock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!ResetN) begin
      idx        <= '0;
      ghostCnt   <= '0;
      blinkPhase <= 1'b0;
      frame      <= '0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
    end else begin
      idx        <= idxNext;
      ghostCnt   <= ghostCntNext;
      blinkPhase <= blinkPhaseNext;
      frame      <= frameNext;
      if (scanTick) seg <= hexToSeg(nibble);
      an <= lit ? ~(Digit0 << idxNext) : '1;
      dp <= lit ? ~frameNext.dpMask[idxNext] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner.
// Each scan step pushes hand-derived expectations with a due cycle, and a negedge checker compares them when the cycle arrives.
module tb_seg_display_scanner;

  localparam int G       = 8;
  localparam int ScanGap = 20;

  logic        MasterClock;
  logic        ResetN;
  logic        scanTick;
  logic        blinkTick;
  logic [15:0] value;
  logic [3:0]  digitEnable;
  logic [3:0]  blinkMask;
  logic [3:0]  dpMask;
  logic        lzBlank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  seg_display_scanner #(.GhostCycles(G), .NumDigits(4)) dut (
    .MasterClock (MasterClock),
    .ResetN      (ResetN),
    .scanTick    (scanTick),
    .blinkTick   (blinkTick),
    .value       (value),
    .digitEnable (digitEnable),
    .blinkMask   (blinkMask),
    .dpMask      (dpMask),
    .lzBlank     (lzBlank),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  typedef struct {
    string      tag;
    int         due;
    logic [3:0] an;
    logic [6:0] seg;
    bit         segCare;
    logic       dp;
  } scoreItem;

  scoreItem scoreboard[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  initial begin
    MasterClock = 1'b0;
    forever #5 MasterClock = ~MasterClock;
  end

  always @(posedge MasterClock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge MasterClock) begin
    for (int i = scoreboard.size() - 1; i >= 0; i--) begin
      if (scoreboard[i].due == cyc) begin
        check({scoreboard[i].tag, ".an"}, 32'(an), 32'(scoreboard[i].an));
        check({scoreboard[i].tag, ".dp"}, 32'(dp), 32'(scoreboard[i].dp));
        if (scoreboard[i].segCare)
          check({scoreboard[i].tag, ".seg"}, 32'(seg), 32'(scoreboard[i].seg));
        scoreboard.delete(i);
      end
    end
  end

  task automatic pushExpect(input string tag, input int due, input logic [3:0] expAn,
                            input logic [6:0] expSeg, input bit segCare, input logic expDp);
    scoreItem item;
    item.tag     = tag;
    item.due     = due;
    item.an      = expAn;
    item.seg     = expSeg;
    item.segCare = segCare;
    item.dp      = expDp;
    scoreboard.push_back(item);
  endtask

  // Called at a negedge. The pulse is sampled at the next posedge and the task returns at the negedge after it.
  task automatic tick(input bit withBlink);
    scanTick  = 1'b1;
    blinkTick = withBlink;
    @(negedge MasterClock);
    scanTick  = 1'b0;
    blinkTick = 1'b0;
  endtask

  task automatic blinkPulse();
    blinkTick = 1'b1;
    @(negedge MasterClock);
    blinkTick = 1'b0;
  endtask

  // One scan step. expAn == 4'b1111 means the new digit is expected to stay dark.
  task automatic scanStep(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                          input logic expDp, input bit withBlink);
    int p;
    bit isLit;
    p     = cyc + 1;
    isLit = (expAn != 4'b1111);
    pushExpect({tag, "@tick+1"}, p, 4'b1111, expSeg, isLit, 1'b1);
    pushExpect({tag, "@ghostEnd"}, p + G - 1, 4'b1111, expSeg, 1'b0, 1'b1);
    pushExpect({tag, "@lit"}, p + G, expAn, expSeg, isLit, expDp);
    pushExpect({tag, "@hold"}, p + ScanGap - 1, expAn, expSeg, isLit, expDp);
    tick(withBlink);
    repeat (ScanGap - 1) @(negedge MasterClock);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    ResetN = 1'b0; scanTick = 1'b0; blinkTick = 1'b0;
    value = 16'h0; digitEnable = 4'h0; blinkMask = 4'h0; dpMask = 4'h0; lzBlank = 1'b0;
    repeat (3) @(negedge MasterClock);
    ResetN = 1'b1;

    // Idle after reset: display stays dark and blank.
    for (int i = 1; i <= 10; i++) pushExpect("idle", cyc + i, 4'b1111, 7'h7F, 1'b1, 1'b1);
    repeat (10) @(negedge MasterClock);

    // Scan order and latency. The shadow regs are clear until the first wrap.
    value = 16'h1234; digitEnable = 4'hF; lzBlank = 1'b0;
    scanStep("pre1", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("pre2", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("pre3", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("d0", 4'b1110, 7'h19, 1'b1, 1'b0);
    scanStep("d1", 4'b1101, 7'h30, 1'b1, 1'b0);
    scanStep("d2", 4'b1011, 7'h24, 1'b1, 1'b0);
    scanStep("d3", 4'b0111, 7'h79, 1'b1, 1'b0);

    // Frame latch: a mid-frame value change waits for the next wrap.
    scanStep("f0", 4'b1110, 7'h19, 1'b1, 1'b0);
    scanStep("f1", 4'b1101, 7'h30, 1'b1, 1'b0);
    scanStep("f2", 4'b1011, 7'h24, 1'b1, 1'b0);
    value = 16'hABCD;
    scanStep("f3", 4'b0111, 7'h79, 1'b1, 1'b0);
    scanStep("g0", 4'b1110, 7'h21, 1'b1, 1'b0);
    scanStep("g1", 4'b1101, 7'h46, 1'b1, 1'b0);
    scanStep("g2", 4'b1011, 7'h03, 1'b1, 1'b0);
    scanStep("g3", 4'b0111, 7'h08, 1'b1, 1'b0);

    // Leading-zero blanking.
    value = 16'h0050; lzBlank = 1'b1;
    scanStep("lz0", 4'b1110, 7'h40, 1'b1, 1'b0);
    scanStep("lz1", 4'b1101, 7'h12, 1'b1, 1'b0);
    scanStep("lz2", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("lz3", 4'b1111, 7'h7F, 1'b1, 1'b0);
    value = 16'h0000;
    scanStep("z0", 4'b1110, 7'h40, 1'b1, 1'b0);
    scanStep("z1", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("z2", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("z3", 4'b1111, 7'h7F, 1'b1, 1'b0);

    // Blink on digit 0, decimal point on digit 1.
    value = 16'h1234; lzBlank = 1'b0; blinkMask = 4'b0001; dpMask = 4'b0010;
    scanStep("b0", 4'b1110, 7'h19, 1'b1, 1'b0);
    scanStep("b1", 4'b1101, 7'h30, 1'b0, 1'b0);
    scanStep("b2", 4'b1011, 7'h24, 1'b1, 1'b0);
    scanStep("b3", 4'b0111, 7'h79, 1'b1, 1'b0);
    blinkPulse();
    scanStep("k0", 4'b1111, 7'h19, 1'b1, 1'b0);
    scanStep("k1", 4'b1101, 7'h30, 1'b0, 1'b0);
    scanStep("k2", 4'b1011, 7'h24, 1'b1, 1'b0);
    scanStep("k3", 4'b0111, 7'h79, 1'b1, 1'b0);
    blinkPulse();
    scanStep("r0", 4'b1110, 7'h19, 1'b1, 1'b0);
    scanStep("r1", 4'b1101, 7'h30, 1'b0, 1'b0);
    scanStep("r2", 4'b1011, 7'h24, 1'b1, 1'b0);
    scanStep("r3", 4'b0111, 7'h79, 1'b1, 1'b0);

    // scanTick and blinkTick in the same cycle both take effect.
    scanStep("sb0", 4'b1111, 7'h19, 1'b1, 1'b1);
    scanStep("sb1", 4'b1101, 7'h30, 1'b0, 1'b0);
    scanStep("sb2", 4'b1011, 7'h24, 1'b1, 1'b0);
    scanStep("sb3", 4'b0111, 7'h79, 1'b1, 1'b0);
    scanStep("sb4", 4'b1110, 7'h19, 1'b1, 1'b1);

    // Retrigger: ticks at T and T+3 advance idx twice and reload the ghost interval.
    p = cyc + 1;
    pushExpect("retrig.first", p + G, 4'b1111, 7'h7F, 1'b0, 1'b1);
    pushExpect("retrig.pre", p + 3 + G - 1, 4'b1111, 7'h7F, 1'b0, 1'b1);
    pushExpect("retrig.lit", p + 3 + G, 4'b1011, 7'h24, 1'b1, 1'b1);
    pushExpect("retrig.hold", p + ScanGap - 1, 4'b1011, 7'h24, 1'b1, 1'b1);
    tick(1'b0);
    repeat (2) @(negedge MasterClock);
    tick(1'b0);
    repeat (ScanGap - 4) @(negedge MasterClock);

    // Reset during a ghost interval.
    p = cyc + 1;
    pushExpect("rst.next", p + 3, 4'b1111, 7'h7F, 1'b1, 1'b1);
    pushExpect("rst.ghost", p + G, 4'b1111, 7'h7F, 1'b1, 1'b1);
    pushExpect("rst.idle", p + ScanGap - 2, 4'b1111, 7'h7F, 1'b1, 1'b1);
    tick(1'b0);
    repeat (2) @(negedge MasterClock);
    ResetN = 1'b0;
    @(negedge MasterClock);
    ResetN = 1'b1;
    repeat (ScanGap - 4) @(negedge MasterClock);

    // After reset idx restarts at 0: three dark ticks, then the wrap lights digit 0.
    scanStep("x1", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("x2", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("x3", 4'b1111, 7'h7F, 1'b1, 1'b0);
    scanStep("x0", 4'b1110, 7'h19, 1'b1, 1'b0);
    scanStep("x1b", 4'b1101, 7'h30, 1'b0, 1'b0);

    for (int w = 0; w < 40 && scoreboard.size() != 0; w++) @(negedge MasterClock);
    check("scoreboard.drain", 32'(scoreboard.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
